// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle shifter for the ALU datapath. It moves the operand
// one bit position per clock and supports logical left, logical right,
// arithmetic right and rotate right. The last bit shifted out is reported on
// cout.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  operand handshake (in_ready is high only in IDLE)
//   B, Sa, Mode     operand, step count, mode
//                   (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   Cin             fill bit for modes 00/01
//   out_valid/ready result handshake
//   fout, cout      result and last bit out; both held stable while
//                   out_valid is high
module shifter_seq #(
    parameter int WIDTH = 8,
    parameter int SA_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] B,
    input  logic [SA_W-1:0]  Sa,
    input  logic [1:0]       Mode,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fout,
    output logic             cout
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SA_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              fill_q, fill_d;
    logic              cout_q, cout_d;
    // in_ready is a register so that it reads 0 in the cycle right after
    // reset. After that it tracks "next state is IDLE", so it equals
    // (state == IDLE).
    logic              rdy_q, rdy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            fill_q  <= 1'b0;
            cout_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            cout_q  <= cout_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (rdy_q && in_valid) begin
                    data_d  = B;
                    cnt_d   = Sa;
                    mode_d  = Mode;
                    fill_d  = Cin;
                    cout_d  = 1'b0;
                    state_d = (Sa != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                unique case (mode_q)
                    2'b00: begin
                        cout_d = data_q[WIDTH-1];
                        data_d = {data_q[WIDTH-2:0], fill_q};
                    end
                    2'b01: begin
                        cout_d = data_q[0];
                        data_d = {fill_q, data_q[WIDTH-1:1]};
                    end
                    2'b10: begin
                        cout_d = data_q[0];
                        data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    end
                    default: begin
                        cout_d = data_q[0];
                        data_d = {data_q[0], data_q[WIDTH-1:1]};
                    end
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SA_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign fout      = data_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  B;
    logic [SW-1:0] Sa;
    logic [1:0]    Mode;
    logic          Cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  fout;
    logic          cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] f;
        logic         c;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    shifter_seq #(.WIDTH(W), .SA_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .B(B), .Sa(Sa), .Mode(Mode), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready), .fout(fout), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Reference behaviour: one step per Sa, written out from the mode table.
    function automatic exp_t model(input logic [W-1:0] b, input logic [SW-1:0] sa,
                                   input logic [1:0] m, input logic c);
        exp_t e;
        logic [W-1:0] d;
        logic co;
        d = b; co = 1'b0;
        for (int i = 0; i < int'(sa); i++) begin
            case (m)
                2'b00:   begin co = d[W-1]; d = d << 1; d[0] = c; end
                2'b01:   begin co = d[0]; d = d >> 1; d[W-1] = c; end
                2'b10:   begin co = d[0]; d = {d[W-1], d[W-1:1]}; end
                default: begin co = d[0]; d = {d[0], d[W-1:1]}; end
            endcase
        end
        e.f = d; e.c = co; e.lat = int'(sa) + 1;
        return e;
    endfunction

    // Push expectation, issue one operand, wait for the result, release it.
    task automatic run_op(input logic [W-1:0] b, input logic [SW-1:0] sa,
                          input logic [1:0] m, input logic c,
                          input logic [W-1:0] ef, input logic ec,
                          output logic [W-1:0] f, output logic co,
                          output int lat, output int acc, output bit to);
        exp_t e;
        int n;
        e.f = ef; e.c = ec; e.lat = int'(sa) + 1;
        exp_q.push_back(e);
        to = 0; n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) to = 1;
        in_valid = 1'b1; B = b; Sa = sa; Mode = m; Cin = c;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0; B = W'($urandom); Sa = SW'($urandom); Mode = 2'($urandom); Cin = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) to = 1;
        f = fout; co = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        B = '0; Sa = '0; Mode = 2'b00; Cin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (fout !== 8'h00) begin n_bad++; $display("FAIL rst_fout: got %h want 00", fout); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b want 0", cout); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    // Directed vectors with hand-computed results.
    task automatic test_directed();
        logic [W-1:0] vb[7]  = '{8'h96, 8'h84, 8'h03, 8'hA5, 8'h81, 8'h81, 8'h81};
        logic [SW-1:0] vs[7] = '{4'd3, 4'd2, 4'd7, 4'd0, 4'd12, 4'd12, 4'd15};
        logic [1:0] vm[7]    = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b11};
        logic vc[7]          = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] xf[7]  = '{8'hB7, 8'hE1, 8'h06, 8'hA5, 8'h00, 8'hFF, 8'h03};
        logic xc[7]          = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] f; logic co; int lat, acc; bit to; exp_t e;
        for (int i = 0; i < 7; i++) begin
            run_op(vb[i], vs[i], vm[i], vc[i], xf[i], xc[i], f, co, lat, acc, to);
            e = exp_q.pop_front();
            n_cmp++; if (to) begin n_bad++; $display("FAIL dir%0d_timeout: got timeout want result", i); end
            n_cmp++; if (f !== e.f) begin n_bad++; $display("FAIL dir%0d_fout: got %h want %h", i, f, e.f); end
            n_cmp++; if (co !== e.c) begin n_bad++; $display("FAIL dir%0d_cout: got %b want %b", i, co, e.c); end
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] f; logic co; int n; exp_t e;
        e.f = 8'hB7; e.c = 1'b0; e.lat = 4;
        exp_q.push_back(e);
        out_ready = 1'b0;
        in_valid = 1'b1; B = 8'h96; Sa = 4'd3; Mode = 2'b00; Cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        e = exp_q.pop_front();
        f = fout; co = cout;
        n_cmp++; if (f !== e.f) begin n_bad++; $display("FAIL bp_fout: got %h want %h", f, e.f); end
        n_cmp++; if (co !== e.c) begin n_bad++; $display("FAIL bp_cout: got %b want %b", co, e.c); end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin in_valid = 1'b1; B = 8'h5A; Sa = 4'd1; Mode = 2'b11; Cin = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || fout !== e.f || cout !== e.c || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b f=%h c=%b r=%b want v=1 f=%h c=%b r=0",
                         k, out_valid, fout, cout, in_ready, e.f, e.c);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_ignored_input: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] f; logic co; int lat, acc; bit to; exp_t e;
        e = model(8'hC3, 4'd5, 2'b11, 1'b0);
        exp_q.push_back(e);
        in_valid = 1'b1; B = 8'hC3; Sa = 4'd5; Mode = 2'b11; Cin = 1'b0;
        @(posedge clk); #1;              // first SHIFT cycle
        in_valid = 1'b0;
        @(posedge clk); #1;              // second SHIFT cycle
        rst = 1'b1;
        @(posedge clk); #1;
        void'(exp_q.pop_front());        // result is lost
        n_cmp++; if (out_valid !== 1'b0 || fout !== 8'h00 || cout !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_outputs: got v=%b f=%h c=%b want v=0 f=00 c=0", out_valid, fout, cout);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        e = model(8'h2C, 4'd5, 2'b00, 1'b1);
        run_op(8'h2C, 4'd5, 2'b00, 1'b1, e.f, e.c, f, co, lat, acc, to);
        e = exp_q.pop_front();
        n_cmp++; if (to || f !== e.f || co !== e.c || lat !== e.lat) begin
            n_bad++; $display("FAIL mid_rst_next_op: got f=%h c=%b lat=%0d want f=%h c=%b lat=%0d", f, co, lat, e.f, e.c, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f, b; logic co, c; logic [SW-1:0] sa; logic [1:0] m;
        int lat, acc, prev_acc, prev_sa; bit to; exp_t e;
        prev_acc = -1; prev_sa = 0;
        for (int i = 0; i < 24; i++) begin
            b = W'($urandom); sa = SW'($urandom); m = 2'($urandom); c = 1'($urandom);
            e = model(b, sa, m, c);
            run_op(b, sa, m, c, e.f, e.c, f, co, lat, acc, to);
            e = exp_q.pop_front();
            n_cmp++; if (to || f !== e.f || co !== e.c) begin
                n_bad++; $display("FAIL b2b%0d_result: got f=%h c=%b want f=%h c=%b", i, f, co, e.f, e.c);
            end
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, e.lat); end
            if (prev_acc >= 0) begin
                n_cmp++; if (acc - prev_acc !== prev_sa + 2) begin
                    n_bad++; $display("FAIL b2b%0d_throughput: got %0d want %0d", i, acc - prev_acc, prev_sa + 2);
                end
            end
            prev_acc = acc; prev_sa = int'(sa);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
